// File: rtl/div_pkg.sv
// Shared constants and FSM state encoding for the sequential divider.
// Datapath width default and iteration count live here so top and bench agree.
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = $clog2(DIV_ITERS);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
endpackage

// File: rtl/div_seq_if.sv
// Start/operand/result bundle between the execute stage and div_seq.
// data_remainder exists only when DIV_REMAINDER_EN is defined.
interface div_seq_if #(parameter int WIDTH = div_pkg::DIV_WIDTH);
  logic [WIDTH-1:0] operandA;
  logic [WIDTH-1:0] operandB;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
`ifdef DIV_REMAINDER_EN
  logic [WIDTH-1:0] data_remainder;
`endif

  modport master (
`ifdef DIV_REMAINDER_EN
    input  data_remainder,
`endif
    output operandA, operandB, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
`ifdef DIV_REMAINDER_EN
    output data_remainder,
`endif
    input  operandA, operandB, ctrl_DIV,
    output data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: trial subtract of the divisor from the shifted remainder.
// Subtract is an add of the inverted divisor with carry-in 1; carry-out set means no borrow.
module div_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH:0] shifted,
  input  logic [WIDTH:0] divisor,
  output logic [WIDTH:0] rem_next,
  output logic           q_bit
);
  logic [WIDTH+1:0] sum;

  assign sum      = {1'b0, shifted} + {1'b0, ~divisor} + {{(WIDTH+1){1'b0}}, 1'b1};
  assign q_bit    = sum[WIDTH+1];
  assign rem_next = q_bit ? sum[WIDTH:0] : shifted;
endmodule

// File: rtl/div_seq.sv
// Signed 32-bit restoring divider, 35 cycles from accepted start to the one-cycle RDY pulse.
// Starts outside IDLE are dropped; DIV_REMAINDER_EN adds the sign-fixed remainder output.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic    clock,
  input  logic    reset,
  div_seq_if.slave bus
);
  state_t state, state_nxt;

  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   divisor;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] dvd;
  logic [CNT_W-1:0] cnt;
  logic             negq, dz;
  logic [WIDTH:0]   rem_sh, rem_next;
  logic [WIDTH-1:0] dvd_sh;
  logic             q_bit;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;
  logic             rdy;
`ifdef DIV_REMAINDER_EN
  logic             negr;
  logic [WIDTH-1:0] remainder_q;
`endif

  assign abs_a = a_reg[WIDTH-1] ? -a_reg : a_reg;
  assign abs_b = b_reg[WIDTH-1] ? -b_reg : b_reg;

  // dvd doubles as the quotient: dividend bits shift out the top, quotient bits in at the bottom
  assign {rem_sh, dvd_sh} = {rem, dvd} << 1;

  div_step #(.WIDTH(WIDTH)) u_step (
    .shifted  (rem_sh),
    .divisor  (divisor),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.ctrl_DIV) state_nxt = PREP;
      PREP:    state_nxt = ITER;
      ITER:    if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rdy = 1'b0;
    if (state == DONE) rdy = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_reg    <= '0;
      b_reg    <= '0;
      divisor  <= '0;
      rem      <= '0;
      dvd      <= '0;
      cnt      <= '0;
      negq     <= 1'b0;
      dz       <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
`ifdef DIV_REMAINDER_EN
      negr        <= 1'b0;
      remainder_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.ctrl_DIV) begin
          a_reg <= bus.operandA;
          b_reg <= bus.operandB;
        end
        PREP: begin
          divisor <= {1'b0, abs_b};
          dvd     <= abs_a;
          rem     <= '0;
          cnt     <= CNT_W'(DIV_ITERS - 1);
          negq    <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
          dz      <= (b_reg == '0);
`ifdef DIV_REMAINDER_EN
          negr    <= a_reg[WIDTH-1];
`endif
        end
        ITER: begin
          rem <= rem_next;
          dvd <= dvd_sh | {{(WIDTH-1){1'b0}}, q_bit};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          // A zero divisor lets every trial succeed, so rem ends as |A|; only the quotient is forced
          result_q <= dz ? '0 : (negq ? -dvd : dvd);
          exc_q    <= dz;
`ifdef DIV_REMAINDER_EN
          remainder_q <= negr ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy;
`ifdef DIV_REMAINDER_EN
  assign bus.data_remainder = remainder_q;
`endif
endmodule

// File: tb/tb_div_seq.sv
// Directed and randomized checks of div_seq against a queue of expected results.
// Remainder checks are compiled in only when DIV_REMAINDER_EN is defined.
module tb_div_seq;
  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        exc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [31:0] prev_q = '0;

  div_seq_if bus ();

  div_seq dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns with the accepting edge just passed (sampled #1 after it).
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.operandA = a;
    bus.operandB = b;
    bus.ctrl_DIV = 1'b1;
    @(posedge clock);
    #1 bus.ctrl_DIV = 1'b0;
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    do begin
      @(posedge clock);
      #1 n++;
    end while (bus.data_resultRDY !== 1'b1 && n < 100);
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_q"}, bus.data_result, e.q);
      chk({tag, "_exc"}, {31'd0, bus.data_exception}, {31'd0, e.exc});
`ifdef DIV_REMAINDER_EN
      chk({tag, "_r"}, bus.data_remainder, e.r);
`endif
      prev_q = e.q;
    end
    @(posedge clock);
    #1 chk({tag, "_pulse"}, {31'd0, bus.data_resultRDY}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r, input logic exc);
    int n;
    exp_t e;
    e.q = q; e.r = r; e.exc = exc;
    sb.push_back(e);
    start_op(a, b);
    chk({tag, "_hold"}, bus.data_result, prev_q);
    wait_rdy(n);
    // RDY is high in the cycle after edge k+34
    chk({tag, "_lat"}, n, 34);
    check_result(tag);
  endtask

  initial begin
    int n;
    int extra;
    logic [31:0] ra, rb;
    exp_t e;

    bus.operandA = '0;
    bus.operandB = '0;
    bus.ctrl_DIV = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_q", bus.data_result, 32'd0);
    chk("rst_exc", {31'd0, bus.data_exception}, 32'd0);
    chk("rst_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
`ifdef DIV_REMAINDER_EN
    chk("rst_r", bus.data_remainder, 32'd0);
`endif
    @(negedge clock);
    reset = 1'b0;

    run_op("p100_7",   32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
    run_op("m100_7",   32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0);
    run_op("p100_m7",  32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0);
    run_op("div0",     32'd5,          32'd0,          32'd0,          32'd5,          1'b1);
    run_op("p9_3",     32'd9,          32'd3,          32'd3,          32'd0,          1'b0);
    run_op("ovf",      32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0);
    run_op("mdiv0",    32'hFFFFFFF6,   32'd0,          32'd0,          32'hFFFFFFF6,   1'b1);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom_range(2, 5000);
      if ($urandom_range(0, 1) == 1) rb = -rb;
      run_op("rand", ra, rb, 32'($signed(ra) / $signed(rb)), 32'($signed(ra) % $signed(rb)), 1'b0);
    end

    // Second start while busy must be dropped.
    e.q = 32'd100; e.r = 32'd0; e.exc = 1'b0;
    sb.push_back(e);
    start_op(32'd1000, 32'd10);
    repeat (9) @(posedge clock);
    start_op(32'd7, 32'd1);
    wait_rdy(n);
    chk("ign_lat", n, 24);
    check_result("ign");
    extra = 0;
    repeat (40) begin
      @(posedge clock);
      #1 if (bus.data_resultRDY === 1'b1) extra++;
    end
    chk("ign_extra_rdy", extra, 0);

    // Reset mid-operation aborts without a RDY pulse.
    start_op(32'd1000, 32'd10);
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("abort_q", bus.data_result, 32'd0);
    chk("abort_exc", {31'd0, bus.data_exception}, 32'd0);
    chk("abort_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    prev_q = '0;
    run_op("p8_2", 32'd8, 32'd2, 32'd4, 32'd0, 1'b0);

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_seq.md
# div_seq

Multicycle 32-bit signed integer divider that undoes what the ALU's carry-lookahead adder path does for multiply-by-repeated-add. It produces quotient, and optionally remainder, by restoring shift-subtract over a fixed iteration count. It sits beside the ALU in the execute stage's multdiv unit. The processor stalls on it until `data_resultRDY` pulses.

## Interface
Parameters:
- `WIDTH`, 32: operand, quotient and remainder width; only 32 is verified.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `operandA`  in  32  dividend, two's complement; sampled only when a start is accepted.
- `operandB`  in  32  divisor, two's complement; sampled only when a start is accepted.
- `ctrl_DIV`  in  1  start request; accepted only in IDLE.
- `data_result`  out  32  quotient, truncated toward zero.
- `data_exception`  out  1  divide-by-zero flag for the last completed operation.
- `data_resultRDY`  out  1  one-cycle completion pulse.
- `data_remainder`  out  32  remainder, with the sign of the dividend; present only with `DIV_REMAINDER_EN`.

## Operation
- Reset values: all outputs 0; state IDLE.
- States and transitions:
  - IDLE: `ctrl_DIV`=1 latches operands and moves to PREP.
  - PREP: takes absolute values into a 33-bit unsigned divisor and 32-bit dividend. Records `negQ` = signA XOR signB, `negR` = signA, and `dz` = (B==0). Clears the 33-bit partial remainder. Loads iteration counter = 31. Moves to ITER.
  - ITER (32 cycles):
    - Shift {rem, dvd} left by 1.
    - Compute trial = rem − divisor (33-bit) through `div_step`.
    - If trial is non-negative, rem = trial and the quotient bit is 1; otherwise rem is kept and the bit is 0.
    - Counter decrements; leave to FIX when the counter is 0.
  - FIX: quotient negated if `negQ`; remainder negated if `negR`. Updates `data_result` and `data_remainder`. Sets `data_exception` = `dz`. Moves to DONE.
  - DONE: `data_resultRDY`=1 for this cycle only. Moves to IDLE.
- Divide by zero: full latency is kept. `data_result` = 0, `data_remainder` = dividend, `data_exception` = 1.
- Overflow case 0x80000000 / 0xFFFFFFFF: |A| = 2^31 fits the 33-bit path and quotient wraps to 0x80000000. `data_exception` = 0 and remainder = 0.
- Outputs hold their last values until the next FIX. They do not change on start.
- `ctrl_DIV` outside IDLE is ignored; no queueing.
- `ctrl_DIV` held high: a new start is accepted in the IDLE cycle after DONE.
- Reset mid-operation: returns to IDLE with outputs zeroed. No RDY pulse is produced for the aborted operation.

## Timing
- Let rising edge k sample `ctrl_DIV`=1 in IDLE. Then:
  - PREP runs in the cycle after edge k.
  - ITER runs in cycles after edges k+1 through k+32.
  - FIX runs in the cycle after edge k+33.
  - `data_resultRDY`=1 in the cycle after edge k+34.
- Latency is 35 cycles from the accepting edge to the RDY cycle. Back-to-back throughput is one operation per 36 cycles.
- `data_result`, `data_remainder` and `data_exception` are valid and stable from the RDY cycle until the next operation's FIX.

## Configuration
- `DIV_REMAINDER_EN` defined:
  - `data_remainder` port exists.
  - The remainder register is sign-fixed in FIX.
- `DIV_REMAINDER_EN` undefined:
  - Port is absent and the sign fix for the remainder is not built.
  - The 33-bit working remainder still exists for iteration.
  - Quotient, exception and timing are identical.

## Structure
- Package `div_pkg` holds:
  - the `WIDTH` default;
  - the iteration count constant `DIV_ITERS` = 32;
  - the state enum {IDLE, PREP, ITER, FIX, DONE}.
- Sub-module `div_step`: combinational 33-bit trial subtract and restore select.
  - Inputs: shifted remainder, divisor.
  - Outputs: next remainder, quotient bit.
  - The subtract is built as add-with-inverted-divisor and carry-in 1, matching the ALU adder style.
- The top holds the FSM, counter, operand/sign registers and output registers.

## Test plan
- 100 / 7 → `data_result` = 14 and `data_remainder` = 2; RDY exactly 35 cycles after the accepting edge; exception 0.
- −100 / 7 (0xFFFFFF9C / 7) → result 0xFFFFFFF2 (−14) and remainder 0xFFFFFFFE (−2). Then 100 / −7 → −14, remainder 2.
- 5 / 0 → result 0, remainder 5, `data_exception` = 1, same 35-cycle latency. A following 9 / 3 → result 3 with exception cleared.
- 0x80000000 / 0xFFFFFFFF → result 0x80000000, remainder 0, exception 0.
- Start 1000 / 10, pulse `ctrl_DIV` with 7 / 1 at cycle 10 → single RDY with result 100; the second request is ignored.
- Start 1000 / 10, assert `reset` at cycle 10 for 1 cycle → no RDY and outputs 0. Start 8 / 2 on the next cycle → result 4 after 35 cycles.
